// File: rtl/ising_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ising_run_ctrl_if
//  Brief    : Bundle of control, array-side and result-stream signals shared
//             between the run sequencer and its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface ising_run_ctrl_if #(
   parameter int N = 3
);
   // batch control and configuration
   logic          start;
   logic          abort;
   logic [15:0]   num_runs;
   logic [7:0]    reset_cycles;
   logic [31:0]   run_cycles;
   logic          busy;
   logic          done;
   // array side
   logic          ising_rstn;
   logic [N-1:0]  phase;
   // result stream
   logic          res_valid;
   logic [N-1:0]  res_data;
   logic [15:0]   res_run;
   logic          res_ready;

   // environment side: drives commands, phase and consumer ready
   modport master (
      output start, abort, num_runs, reset_cycles, run_cycles, phase, res_ready,
      input  busy, done, ising_rstn, res_valid, res_data, res_run
   );

   // sequencer side
   modport slave (
      input  start, abort, num_runs, reset_cycles, run_cycles, phase, res_ready,
      output busy, done, ising_rstn, res_valid, res_data, res_run
   );
endinterface
`default_nettype wire

// File: rtl/ising_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ising_run_ctrl
//  Brief    : Anneal-run sequencer. Pulses the array run reset, lets it run,
//             captures the phase word per run into a FWFT result FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module ising_run_ctrl #(
   parameter int N     = 3,
   parameter int DEPTH = 4
) (
   input  wire logic       clk,
   input  wire logic       axi_rstn,
   ising_run_ctrl_if.slave bus
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_EW = N + 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RESET   = 3'd1,
      S_RUN     = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [15:0]       r_num_runs;
   logic [7:0]        r_reset_len;   // already clamped to >= 1
   logic [31:0]       r_run_len;     // already clamped to >= 1
   logic [31:0]       r_cnt;
   logic [31:0]       w_cnt_nxt;
   logic [15:0]       r_run_idx;
   logic [15:0]       w_idx_nxt;
   logic [15:0]       w_idx_inc;
   logic              w_latch;
   logic              w_push;
   logic              w_pop;

   logic [7:0]        w_reset_len_in;
   logic [31:0]       w_run_len_in;

   // result FIFO storage and pointers (extra MSB is the wrap bit)
   logic [c_EW-1:0]   r_mem [DEPTH];
   logic [c_AW:0]     r_wr_ptr;
   logic [c_AW:0]     r_rd_ptr;
   logic [c_AW:0]     w_wr_nxt;
   logic [c_AW:0]     w_rd_nxt;
   logic              w_full;
   logic              w_empty;
   logic [c_EW-1:0]   w_push_entry;
   logic [c_EW-1:0]   w_head;

   // registered outputs
   logic              r_ising_rstn;
   logic              r_busy;
   logic              r_done;
   logic              r_res_valid;
   logic [N-1:0]      r_res_data;
   logic [15:0]       r_res_run;

   assign w_reset_len_in = (bus.reset_cycles == 8'd0)  ? 8'd1  : bus.reset_cycles;
   assign w_run_len_in   = (bus.run_cycles   == 32'd0) ? 32'd1 : bus.run_cycles;
   assign w_idx_inc      = r_run_idx + 16'd1;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop        = !w_empty && bus.res_ready;
   assign w_push_entry = {bus.phase, r_run_idx};
   assign w_wr_nxt     = r_wr_ptr + {{c_AW{1'b0}}, w_push};
   assign w_rd_nxt     = r_rd_ptr + {{c_AW{1'b0}}, w_pop};

   // next-state, counter and push decision; abort overrides everything last
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_run_idx;
      w_push      = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               w_latch   = 1'b1;
               w_idx_nxt = 16'd0;
               if (bus.num_runs == 16'd0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RESET;
                  w_cnt_nxt   = {24'd0, w_reset_len_in - 8'd1};
               end
            end
         end
         S_RESET: begin
            if (r_cnt == 32'd0) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = r_run_len - 32'd1;
            end else begin
               w_cnt_nxt = r_cnt - 32'd1;
            end
         end
         S_RUN: begin
            if (r_cnt == 32'd0) begin
               w_state_nxt = S_CAPTURE;
            end else begin
               w_cnt_nxt = r_cnt - 32'd1;
            end
         end
         S_CAPTURE: begin
            // a simultaneous pop frees the slot even when the FIFO is full
            if (!w_full || bus.res_ready) begin
               w_push    = 1'b1;
               w_idx_nxt = w_idx_inc;
               w_cnt_nxt = {24'd0, r_reset_len - 8'd1};
               w_state_nxt = (w_idx_inc == r_num_runs) ? S_DONE : S_RESET;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (bus.abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_push      = 1'b0;
         w_idx_nxt   = r_run_idx;
      end
   end

   // head of FIFO after this edge; bypass the entry being written when it
   // lands directly at the new read position
   always_comb begin
      w_head = '0;
      if (w_wr_nxt != w_rd_nxt) begin
         if (w_push && (r_wr_ptr[c_AW-1:0] == w_rd_nxt[c_AW-1:0])) begin
            w_head = w_push_entry;
         end else begin
            w_head = r_mem[w_rd_nxt[c_AW-1:0]];
         end
      end
   end

   // state, config, counters, pointers and registered outputs
   always_ff @(posedge clk) begin
      if (!axi_rstn) begin
         r_state      <= S_IDLE;
         r_num_runs   <= 16'd0;
         r_reset_len  <= 8'd1;
         r_run_len    <= 32'd1;
         r_cnt        <= 32'd0;
         r_run_idx    <= 16'd0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_ising_rstn <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_res_run    <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_run_idx <= w_idx_nxt;
         if (w_latch) begin
            r_num_runs  <= bus.num_runs;
            r_reset_len <= w_reset_len_in;
            r_run_len   <= w_run_len_in;
         end
         r_wr_ptr     <= w_wr_nxt;
         r_rd_ptr     <= w_rd_nxt;
         r_ising_rstn <= (w_state_nxt == S_RUN) || (w_state_nxt == S_CAPTURE);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= (w_state_nxt == S_DONE);
         r_res_valid  <= (w_wr_nxt != w_rd_nxt);
         r_res_data   <= w_head[c_EW-1:16];
         r_res_run    <= w_head[15:0];
      end
   end

   // FIFO storage write; contents need no reset, pointers define validity
   always_ff @(posedge clk) begin
      if (axi_rstn && w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_entry;
      end
   end

   assign bus.ising_rstn = r_ising_rstn;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.res_valid  = r_res_valid;
   assign bus.res_data   = r_res_data;
   assign bus.res_run    = r_res_run;

endmodule
`default_nettype wire

// File: doc/ising_run_ctrl.md
# ising_run_ctrl

Run sequencer that sits directly ahead of the Ising core and sampler. It drives their active-low run reset (`ising_rstn`) through repeated anneal runs and captures the N-bit `phase` word at the end of each run. Results go into a small FIFO drained by a valid/ready consumer, so software or a downstream best-solution tracker can collect many independent solutions per start command.

## Interface

Parameters:
- `N`, 3: spin count; width of `phase` and `res_data`.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `axi_rstn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a batch; sampled only in IDLE.
- `abort`, in, 1: terminate the batch.
- `num_runs`, in, 16: runs per batch; latched at start.
- `reset_cycles`, in, 8: cycles `ising_rstn` is held low before each run; latched at start.
- `run_cycles`, in, 32: cycles `ising_rstn` is high before capture; latched at start.
- `ising_rstn`, out, 1: run reset to the core/sampler, active-low.
- `phase`, in, N: sampler output.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a batch completes normally.
- `res_valid`, out, 1: FIFO non-empty.
- `res_data`, out, N: phase at head of FIFO.
- `res_run`, out, 16: 0-based run index at head of FIFO.
- `res_ready`, in, 1: pop when `res_valid && res_ready`.

## Operation

- FSM states: IDLE, RESET, RUN, CAPTURE, DONE.
- IDLE:
  - `start=1 && abort=0` latches config, clears the run index, and goes to RESET.
  - If latched `num_runs==0`, go straight to DONE instead.
- RESET:
  - `ising_rstn=0` for exactly max(`reset_cycles`,1) cycles, then RUN.
- RUN:
  - `ising_rstn=1` for exactly max(`run_cycles`,1) cycles, then CAPTURE.
- CAPTURE:
  - `ising_rstn` stays 1.
  - If the FIFO has space, push {`phase`, run index} at the clock edge ending this cycle.
  - After the push, increment the run index. Go to DONE if the incremented index equals `num_runs`, else RESET.
- CAPTURE with FIFO full:
  - Stay in CAPTURE (array keeps running, no push).
  - Full with `res_ready=1` in the same cycle counts as space: pop and push together.
- DONE: `done=1` for one cycle, then IDLE.
- `start` while `busy` is ignored. Config input changes mid-batch have no effect.
- `abort=1` in any non-IDLE state:
  - Next state IDLE, `ising_rstn=0`, no `done` pulse.
  - FIFO contents are kept.
  - Abort wins over `start` and over a capture push in the same cycle.
- FIFO:
  - First-word-fall-through; `res_data`/`res_run` are valid whenever `res_valid`.
  - Pop on empty is ignored.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- Run index is 16 bits. `num_runs` ≤ 65535, so the index never wraps inside a batch.

## Timing

- Every output is registered.
- Reset values: `ising_rstn=0`, `busy=0`, `done=0`, `res_valid=0`, `res_data=0`, `res_run=0`. FIFO is empty and the FSM is in IDLE.
- `axi_rstn` low mid-batch restores all reset values at the next edge and flushes the FIFO.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled.
  - `busy` and RESET (`ising_rstn=0`) begin in cycle 1.
- Per run: R = max(`reset_cycles`,1), U = max(`run_cycles`,1). Each run takes R+U+1 cycles with no stall.
- `done` is asserted in cycle `num_runs`·(R+U+1)+1 when there is no backpressure. For `num_runs==0`, `done` is asserted in cycle 1.
- The pushed entry shows `res_valid=1` in the cycle after CAPTURE, when the FIFO was empty.
- `phase` is sampled on the edge that ends CAPTURE, while `ising_rstn=1`.

## Test plan

- **Single run.** Stimulus: `num_runs=1`, `reset_cycles=2`, `run_cycles=5`, `phase`=3'b101. Required:
  - `ising_rstn` low in cycles 1–2 and high in cycles 3–8.
  - `res_valid`, `res_data=101`, `res_run=0` from cycle 9.
  - `done` in cycle 9 only; `busy` low from cycle 10.
- **Backpressure.** Stimulus: DEPTH=4, `num_runs=6`, `reset_cycles=1`, `run_cycles=3`, `res_ready=0`. Required:
  - After 4 pushes the FSM holds in CAPTURE with `ising_rstn=1` and `busy=1`.
  - Raising `res_ready` drains `res_run` 0,1,2,3,4,5 in order.
  - Exactly one `done`; no entry lost or duplicated.
- **Zero-length batch.** Stimulus: `num_runs=0`. Required:
  - `done` in cycle 1, `busy` high only in cycle 1.
  - `ising_rstn` stays 0; FIFO stays empty.
- **Abort.** Stimulus: `num_runs=4`, abort in the 2nd RUN cycle of run 2. Required:
  - `ising_rstn=0` and `busy=0` on the next cycle; no `done`.
  - FIFO holds `res_run` 0 and 1.
  - A new `start` runs normally.
- **Zero counts and ignored start.** Stimulus: `reset_cycles=0`, `run_cycles=0`, `num_runs=2`. Required:
  - Each run lasts 3 cycles; `done` in cycle 7.
  - A `start` pulse in cycle 3 changes nothing.
- **Reset mid-batch.** Stimulus: `axi_rstn` low for 1 cycle during RUN with 2 FIFO entries. Required:
  - All outputs at reset values on the next cycle; `res_valid=0`.
  - FSM in IDLE and accepts a new `start`.
